// File: rtl/tt_sweep_pkg.sv
// Shared constants and FSM encoding for the truth-table sweep capture block.
// Latency: n/a (definitions only). Backpressure: n/a.
package tt_sweep_pkg;
    localparam int N_IN_DEF       = 7;
    localparam int TT_W_DEF       = 2 ** N_IN_DEF;
    localparam int SAMPLE_LAT_MIN = 1;
    localparam int SAMPLE_LAT_MAX = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SWEEP = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    function automatic int clamp_lat(input int lat);
        if (lat < SAMPLE_LAT_MIN) return SAMPLE_LAT_MIN;
        if (lat > SAMPLE_LAT_MAX) return SAMPLE_LAT_MAX;
        return lat;
    endfunction
endpackage

// File: rtl/tt_sweep_capture_if.sv
// Control, FUT and result signals of the sweep capture block (TT_COMPARE_EN adds the compare group).
// Latency: n/a. Backpressure: none, start is a request accepted only when idle.
interface tt_sweep_capture_if
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
);
    localparam int TT_W = 2 ** N_IN;

    logic            start;
    logic            abort;
    logic [N_IN-1:0] x_o;
    logic            f_i;
    logic            busy;
    logic            done;
    logic [TT_W-1:0] tt_o;
    logic            tt_valid;
`ifdef TT_COMPARE_EN
    logic [TT_W-1:0] tt_exp;
    logic            tt_match;
    logic [N_IN-1:0] mm_idx;

    modport master (input start, abort, f_i, tt_exp,
                    output x_o, busy, done, tt_o, tt_valid, tt_match, mm_idx);
    modport slave  (output start, abort, f_i, tt_exp,
                    input x_o, busy, done, tt_o, tt_valid, tt_match, mm_idx);
`else
    modport master (input start, abort, f_i,
                    output x_o, busy, done, tt_o, tt_valid);
    modport slave  (output start, abort, f_i,
                    input x_o, busy, done, tt_o, tt_valid);
`endif
endinterface

// File: rtl/tt_tag_pipe.sv
// DEPTH-stage shift of {valid, index} tags following each driven pattern to its sample edge.
// Latency: DEPTH edges. Backpressure: none; flush clears every stage synchronously.
module tt_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx
);
    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][IDX_W-1:0] idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            idx_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            idx_q[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_idx = idx_q[DEPTH-1];
endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all 2**N_IN patterns into a FUT and captures its truth table; optional TT_COMPARE_EN checks it.
// Latency: start edge to done edge = TT_W-1+SAMPLE_LAT. Backpressure: start ignored while busy; abort cancels.
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter  int N_IN       = N_IN_DEF,
    parameter  int SAMPLE_LAT = 1,
    localparam int TT_W       = 2 ** N_IN
) (
    input logic               clk,
    input logic               rst_n,
    tt_sweep_capture_if.master bus
);
    localparam int LAT = clamp_lat(SAMPLE_LAT);

    state_t          state_q;
    logic [N_IN-1:0] x_q;
    logic            busy_q;
    logic            done_q;
    logic            valid_q;
    logic [TT_W-1:0] tt_q;

    logic            start_acc;
    logic            abort_acc;
    logic            last_pat;
    logic            cap_en;
    logic            sweep_end;
    logic            tag_in_vld;
    logic [N_IN-1:0] tag_in_idx;
    logic            tag_vld;
    logic [N_IN-1:0] tag_idx;

    assign start_acc = (state_q == ST_IDLE) && bus.start;
    assign abort_acc = (state_q != ST_IDLE) && bus.abort;
    assign last_pat  = &x_q;
    assign cap_en    = tag_vld && !abort_acc;
    assign sweep_end = cap_en && (&tag_idx);

    // The tag enters the pipe on the same edge that puts its pattern on x_o.
    always_comb begin
        tag_in_vld = 1'b0;
        tag_in_idx = '0;
        if (start_acc) begin
            tag_in_vld = 1'b1;
        end else if (state_q == ST_SWEEP && !abort_acc && !last_pat) begin
            tag_in_vld = 1'b1;
            tag_in_idx = x_q + N_IN'(1);
        end
    end

    tt_tag_pipe #(
        .DEPTH (LAT),
        .IDX_W (N_IN)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (abort_acc),
        .in_vld  (tag_in_vld),
        .in_idx  (tag_in_idx),
        .out_vld (tag_vld),
        .out_idx (tag_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_acc) begin
                state_q <= ST_SWEEP;
                x_q     <= '0;
                busy_q  <= 1'b1;
                valid_q <= 1'b0;
            end else if (abort_acc) begin
                state_q <= ST_IDLE;
                x_q     <= '0;
                busy_q  <= 1'b0;
            end else if (sweep_end) begin
                // With a one-edge sample latency this coincides with the x_o wrap, skipping DRAIN.
                state_q <= ST_IDLE;
                x_q     <= '0;
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
                done_q  <= 1'b1;
            end else if (state_q == ST_SWEEP) begin
                if (last_pat) begin
                    state_q <= ST_DRAIN;
                    x_q     <= '0;
                end else begin
                    x_q <= x_q + N_IN'(1);
                end
            end else if (state_q != ST_DRAIN) begin
                state_q <= ST_IDLE;
            end
        end
    end

    // Bits not yet rewritten keep the previous sweep's values; tt_valid qualifies the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q <= '0;
        end else if (cap_en) begin
            tt_q[tag_idx] <= bus.f_i;
        end
    end

    assign bus.x_o      = x_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.tt_o     = tt_q;
    assign bus.tt_valid = valid_q;

`ifdef TT_COMPARE_EN
    logic            mm_seen_q;
    logic            match_q;
    logic [N_IN-1:0] mm_idx_q;
    logic            bit_mm;

    assign bit_mm = bus.f_i != bus.tt_exp[tag_idx];

    // Samples arrive in ascending index order, so the first mismatch is the lowest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_seen_q <= 1'b0;
            match_q   <= 1'b0;
            mm_idx_q  <= '0;
        end else if (start_acc) begin
            mm_seen_q <= 1'b0;
            match_q   <= 1'b0;
            mm_idx_q  <= '0;
        end else if (cap_en) begin
            if (bit_mm && !mm_seen_q) begin
                mm_seen_q <= 1'b1;
                mm_idx_q  <= tag_idx;
            end
            if (sweep_end) begin
                match_q <= !mm_seen_q && !bit_mm;
            end
        end
    end

    assign bus.tt_match = match_q;
    assign bus.mm_idx   = mm_idx_q;
`endif
endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: two instances (sample latency 1 and 3) driving bench-side FUTs.
// Expected tables and latencies are queued at start and popped at the done pulse.
module tb_tt_sweep_capture;
    import tt_sweep_pkg::*;

    typedef struct {
        logic [127:0] tt;
        int           lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   fsel;
    int   dsel;
    exp_t sb_q[$];

    tt_sweep_capture_if #(.N_IN(7)) if1 ();
    tt_sweep_capture_if #(.N_IN(7)) if3 ();

    tt_sweep_capture #(.N_IN(7), .SAMPLE_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
    tt_sweep_capture #(.N_IN(7), .SAMPLE_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FUT for dut1: x0, or majority of x0..x2.
    assign if1.f_i = (fsel == 0) ? if1.x_o[0]
                   : ((if1.x_o[0] & if1.x_o[1]) | (if1.x_o[0] & if1.x_o[2]) | (if1.x_o[1] & if1.x_o[2]));

    // FUT for dut3: x6 through two registers.
    logic r1, r2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1 <= 1'b0;
            r2 <= 1'b0;
        end else begin
            r1 <= if3.x_o[6];
            r2 <= r1;
        end
    end
    assign if3.f_i = r2;

    logic         m_busy, m_done, m_valid;
    logic [6:0]   m_x;
    logic [127:0] m_tt;
    assign m_busy  = (dsel == 3) ? if3.busy     : if1.busy;
    assign m_done  = (dsel == 3) ? if3.done     : if1.done;
    assign m_valid = (dsel == 3) ? if3.tt_valid : if1.tt_valid;
    assign m_x     = (dsel == 3) ? if3.x_o      : if1.x_o;
    assign m_tt    = (dsel == 3) ? if3.tt_o     : if1.tt_o;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model(input int sel);
        logic [127:0] t;
        logic [6:0]   kb;
        t = '0;
        for (int k = 0; k < 128; k++) begin
            kb = 7'(k);
            case (sel)
                0:       t[k] = kb[0];
                1:       t[k] = kb[6];
                default: t[k] = (kb[0] & kb[1]) | (kb[0] & kb[2]) | (kb[1] & kb[2]);
            endcase
        end
        return t;
    endfunction

    task automatic set_start(input logic v);
        if (dsel == 3) if3.start = v;
        else           if1.start = v;
    endtask

    task automatic sweep(input int d, input int sel, input bit spam);
        exp_t e;
        exp_t got;
        int   n;
        bit   seen;
        dsel = d;
        @(negedge clk);
        if (d == 1) fsel = sel;
        e.tt  = model(sel);
        e.lat = 127 + ((d == 3) ? 3 : 1);
        sb_q.push_back(e);
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        check("start_busy", m_busy, 1);
        check("start_x", m_x, 0);
        check("start_valid", m_valid, 0);
        n    = 0;
        seen = 0;
        while (!seen && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (m_done) seen = 1;
            set_start(spam && !seen && (n % 7 == 3));
        end
        check("done_seen", seen, 1);
        if (seen) begin
            got = sb_q.pop_front();
            check("latency", n, got.lat);
            check("tt", m_tt, got.tt);
            check("done_valid", m_valid, 1);
            check("done_busy", m_busy, 0);
            check("done_x", m_x, 0);
            @(posedge clk); #1;
            check("done_one_cycle", m_done, 0);
            check("valid_hold", m_valid, 1);
        end
    endtask

    initial begin
        int dones;
        logic [127:0] flip;
        checks   = 0;
        failures = 0;
        fsel     = 0;
        dsel     = 1;
        rst_n    = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0;
        if3.start = 1'b0; if3.abort = 1'b0;
`ifdef TT_COMPARE_EN
        if1.tt_exp = '0;
        if3.tt_exp = '0;
`endif
        #12;
        check("rst_busy", if1.busy, 0);
        check("rst_done", if1.done, 0);
        check("rst_x", if1.x_o, 0);
        check("rst_tt", if1.tt_o, 0);
        check("rst_valid", if1.tt_valid, 0);
        check("rst_busy3", if3.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        sweep(1, 0, 1'b0);
        check("tt_aaaa", if1.tt_o, {16{8'hAA}});

        @(negedge clk);
        if1.abort = 1'b1;
        @(negedge clk);
        if1.abort = 1'b0;
        check("idle_abort_valid", if1.tt_valid, 1);
        check("idle_abort_busy", if1.busy, 0);

        sweep(3, 1, 1'b0);
        check("tt_x6", if3.tt_o, {{64{1'b1}}, {64{1'b0}}});

        sweep(1, 2, 1'b1);
        check("tt_maj", if1.tt_o, {16{8'hE8}});
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (if1.done) dones++;
        end
        check("maj_extra_done", dones, 0);

        // Abort at edge 40 of a sweep.
        dsel = 1;
        @(negedge clk);
        fsel = 0;
        if1.start = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        if1.abort = 1'b1;
        @(posedge clk); #1;
        if1.abort = 1'b0;
        check("abort_busy", if1.busy, 0);
        check("abort_x", if1.x_o, 0);
        check("abort_valid", if1.tt_valid, 0);
        check("abort_done", if1.done, 0);
        dones = 0;
        repeat (140) begin
            @(posedge clk); #1;
            if (if1.done) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_valid_hold", if1.tt_valid, 0);
        sweep(1, 0, 1'b0);

`ifdef TT_COMPARE_EN
        flip = 128'd1;
        flip = flip << 77;
        if1.tt_exp = model(2) ^ flip;
        sweep(1, 2, 1'b0);
        check("cmp_match_bad", if1.tt_match, 0);
        check("cmp_idx_bad", if1.mm_idx, 77);
        if1.tt_exp = model(2);
        sweep(1, 2, 1'b0);
        check("cmp_match_ok", if1.tt_match, 1);
        check("cmp_idx_ok", if1.mm_idx, 0);
`else
        flip = '0;
`endif

        // Asynchronous reset between edges mid-sweep.
        dsel = 1;
        @(negedge clk);
        fsel = 0;
        if1.start = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", if1.busy, 0);
        check("mid_rst_x", if1.x_o, 0);
        check("mid_rst_tt", if1.tt_o, 0);
        check("mid_rst_valid", if1.tt_valid, 0);
        check("mid_rst_done", if1.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (if1.done || if3.done) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        check("mid_rst_idle_busy", if1.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
